// File: rtl/led_matrix_scanner.sv
// Scan driver for the 8x8 tri-colour LED matrix and two-digit 7-segment score.
// Keeps a double-buffered frame store and swaps banks only at frame boundaries.
module led_matrix_scanner #(
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_x,
    input  logic [2:0]  wr_y,
    input  logic [2:0]  wr_rgb,
    input  logic        clr,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    input  logic [3:0]  score_ones,
    input  logic [3:0]  score_tens,
    output logic [0:27] led,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic [0:3]  COM
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       col;
    logic [2:0]       col_next;
    logic             phase;
    logic             phase_next;
    logic             front_sel;
    logic             pending;
    logic             cnt_wrap;
    logic             frame_wrap;
    logic             do_swap;
    logic             blank_next;

    logic [2:0]       bank      [2][64];
    logic [2:0]       back_next [64];
    logic [2:0]       disp      [8];

    logic [0:27]      led_next;
    logic [6:0]       seg;
    logic [6:0]       seg_next;
    logic [3:0]       digit;

    always_comb begin
        cnt_wrap   = (cnt == CNT_LAST);
        frame_wrap = cnt_wrap && (col == 3'd7);
        do_swap    = frame_wrap && (pending || swap_req);
        cnt_next   = cnt_wrap ? '0 : cnt + 1'b1;
        col_next   = cnt_wrap ? col + 3'd1 : col;
        phase_next = phase ^ cnt_wrap;
        blank_next = (cnt_next < BLANK_END);
    end

    // Clear happens before the write, so a same-cycle write survives the clear.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            back_next[i] = clr ? 3'b000 : bank[~front_sel][i];
        end
        if (wr_en) begin
            back_next[{wr_x, wr_y}] = wr_rgb;
        end
    end

    // Outputs are built from post-edge state; on a swap edge the old back bank is what gets shown.
    always_comb begin
        led_next = '1;
        for (int y = 0; y < 8; y++) begin
            disp[y] = do_swap ? back_next[{col_next, 3'(y)}]
                              : bank[front_sel][{col_next, 3'(y)}];
            for (int ch = 0; ch < 3; ch++) begin
                led_next[8*ch + 7 - y] = blank_next | ~disp[y][2 - ch];
            end
        end
        led_next[24:26] = col_next;
        led_next[27]    = 1'b1;
    end

    always_comb begin
        digit = phase_next ? score_tens : score_ones;
        case (digit)
            4'd0:    seg_next = 7'b0000001;
            4'd1:    seg_next = 7'b1001111;
            4'd2:    seg_next = 7'b0010010;
            4'd3:    seg_next = 7'b0000110;
            4'd4:    seg_next = 7'b1001100;
            4'd5:    seg_next = 7'b0100100;
            4'd6:    seg_next = 7'b0100000;
            4'd7:    seg_next = 7'b0001111;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0000100;
            default: seg_next = 7'b1111111;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int bk = 0; bk < 2; bk++) begin
                for (int i = 0; i < 64; i++) begin
                    bank[bk][i] <= 3'b000;
                end
            end
            front_sel   <= 1'b0;
            pending     <= 1'b0;
            cnt         <= '0;
            col         <= 3'd0;
            phase       <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            led         <= {24'hFF_FFFF, 4'h0};
            seg         <= 7'b1111111;
            COM         <= 4'b1111;
        end else begin
            for (int i = 0; i < 64; i++) begin
                bank[~front_sel][i] <= back_next[i];
            end
            front_sel   <= front_sel ^ do_swap;
            pending     <= do_swap ? 1'b0 : (pending | swap_req);
            cnt         <= cnt_next;
            col         <= col_next;
            phase       <= phase_next;
            swap_ack    <= do_swap;
            frame_start <= frame_wrap;
            led         <= led_next;
            seg         <= seg_next;
            COM         <= phase_next ? 4'b1101 : 4'b1110;
        end
    end

    assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Display back end for the 8x8 tri-colour LED matrix and the two-digit 7-segment score display. Game logic writes pixels into a double-buffered 8x8x3 frame store and requests a buffer swap. The block scans the front buffer column by column onto the `led` bus, with per-row blanking, and multiplexes the BCD score onto `COM` and the segment lines. It replaces per-module hand-drawn scan code, so game logic only writes pixels.

## Interface

- `SCAN_DIV`, 25000, CLK cycles per row period; must be >= 2.
- `BLANK_CYCLES`, 16, cycles at the start of each row period with all colour outputs off; must be < `SCAN_DIV`.

- `CLK` in 1, system clock; the only clock.
- `reset` in 1, synchronous, active-high.
- `wr_en` in 1, pixel write strobe into the back buffer.
- `wr_x` in 3, column (scan index) of the pixel.
- `wr_y` in 3, height of the pixel.
- `wr_rgb` in 3, {R,G,B}, 1 = lit.
- `clr` in 1, clears the whole back buffer in one cycle.
- `swap_req` in 1, requests a front/back swap.
- `swap_ack` out 1, one-cycle pulse when the swap takes effect.
- `frame_start` out 1, one-cycle pulse each time the scan wraps to column 0.
- `score_ones` in 4, BCD ones digit.
- `score_tens` in 4, BCD tens digit.
- `led` out [0:27], matrix bus:
  - [0:7] red, [8:15] green, [16:23] blue, all active-low.
  - Within each colour, bit 8c+(7-y) drives height y.
  - [24:26] current column.
  - [27] matrix enable.
- `a,b,c,d,e,f,g` out 1 each, segments, active-low.
- `COM` out [0:3], digit select, active-low.

## Operation

- Storage: two banks of 64 x 3 bits. `front_sel` selects the displayed bank; writes, `clr` and swaps all target bank `~front_sel`, evaluated on the current edge before any swap.
- `clr` together with `wr_en` in the same cycle: clear is applied first, then the write, so only the written pixel remains lit.
- Prescaler `cnt` runs 0..SCAN_DIV-1. When it wraps:
  - the column advances 0..7 and 7 wraps to 0;
  - the digit phase toggles.
- Colour output for column x, height y, channel c: `led[8c+7-y] = ~pixel[front][x][y][c]`.
  - All of `led[0:23]` is forced to 1 while `cnt < BLANK_CYCLES`.
  - `led[24:26]` = current column.
  - `led[27]` = 1, except 0 while `reset` is asserted.
- Swap logic:
  - `swap_req` sets a sticky `pending` flag.
  - On the frame-boundary edge (column 7 to 0), if `pending` is set or `swap_req` is high that cycle: `front_sel` toggles, `swap_ack` = 1 for one cycle, and `pending` clears.
  - Requests made while already pending merge into that one swap.
  - After a swap the new back bank holds the previous front image.
- Score display:
  - Digit phase 0: `COM` = 4'b1110, showing `score_ones`.
  - Digit phase 1: `COM` = 4'b1101, showing `score_tens`.
  - Segment encodings {a..g}: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - BCD values 10-15 display 1111111.
- Reset:
  - both banks cleared; `front_sel`=0; `pending`=0; `cnt`=0; column=0; digit phase=0;
  - `led[0:23]` all 1; `led[24:26]`=0; `led[27]`=0;
  - `swap_ack`=0; `frame_start`=0; `COM`=4'b1111; segments=1111111.
  - Reset mid-frame aborts any pending swap.

## Timing

- All outputs are registered. Column index, blanking, `COM` and segments change on the same edge, the one where `cnt` wraps to 0.
- Colours turn on at the edge where `cnt` becomes `BLANK_CYCLES`.
- A row period is `SCAN_DIV` cycles; a frame is 8 x `SCAN_DIV` cycles.
- `front_sel`, `swap_ack` and `frame_start` update on the edge that starts column 0. Column 0 starts blanked, so a swap never tears.
- Write latency: a pixel is in the back bank one edge after `wr_en`. It becomes visible only after the next swap, at the first unblanked cycle of its column.
- First `frame_start` after reset: 8 x `SCAN_DIV` cycles after reset deasserts.

## Test plan

Use `SCAN_DIV`=8 and `BLANK_CYCLES`=2 for all scenarios.

1. Hold `reset` 3 cycles, then release -> all reset values hold during reset; `led[27]`=1 on the first cycle after release; `frame_start` first pulses 64 cycles after release.
2. Write x=3, y=0, rgb=100, then `swap_req` -> `swap_ack` pulses at the next boundary.
   - Column 3, cycles 2-7 of its period: `led[0:7]`=8'b11111110 and `led[8:23]` all 1.
   - Cycles 0-1 of that period: `led[0:23]` all 1.
3. Free-run one frame -> `led[24:26]` steps 0..7 every 8 cycles; `frame_start` pulses every 64 cycles.
4. `swap_req` at column 2 and again at column 5 -> exactly one `swap_ack`, on the column 7 to 0 edge; `front_sel` toggles once.
5. Back buffer full of 111; assert `clr` and `wr_en` (x=0, y=7, rgb=010) in the same cycle, then swap -> only `led[8]`=0, during column 0.
6. `score_ones`=4, `score_tens`=2 -> alternating row periods show `COM`=1110 with segments 1001100, then `COM`=1101 with 0010010. `score_ones`=12 -> segments 1111111.
